// File: rtl/mia_add_pkg.sv
// Shared definitions for the packed matrix-add sequencer.
// Build option: define MIA_ADD_SAT_EN for saturating sums (default wraps).
package mia_add_pkg;

    localparam int DW    = 16;
    localparam int NPAIR = 8;
    localparam int CNT_W = $clog2(2*NPAIR);

    typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;

    // Bit offset of pair k inside the packed result (pair 0 sits in the MSBs)
    function automatic int slot_off(input int k, input int npair, input int dw);
        return (npair - 1 - k) * dw;
    endfunction

endpackage

// File: rtl/mia_add_unit.sv
// Shared DW-bit unsigned adder used for every operand pair.
// Build option: MIA_ADD_SAT_EN clamps to all-ones on carry-out, otherwise the sum wraps.
module mia_add_unit #(
    parameter int DW = 16
) (
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    output logic [DW-1:0] o_sum
);

`ifdef MIA_ADD_SAT_EN
    logic [DW:0] w_full;
    assign w_full = {1'b0, i_a} + {1'b0, i_b};
    // Carry-out means the true sum does not fit: clamp to the maximum value
    assign o_sum  = w_full[DW] ? '1 : w_full[DW-1:0];
`else
    // Carry is dropped, result is modulo 2^DW
    assign o_sum = i_a + i_b;
`endif

endmodule

// File: rtl/matrix_add_seq_ctrl.sv
// Sequencer for the packed matrix adder: takes 2*NPAIR elements serially,
// sums consecutive pairs on one shared adder and presents the packed row.
// Build option: MIA_ADD_SAT_EN (saturating sums, handled in mia_add_unit).
module matrix_add_seq_ctrl #(
    parameter int DW    = mia_add_pkg::DW,
    parameter int NPAIR = mia_add_pkg::NPAIR
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DW-1:0]       in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [NPAIR*DW-1:0] out,
    output logic                busy
);
    import mia_add_pkg::*;

    localparam int CW = $clog2(2*NPAIR);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CW-1:0]        r_cnt;
    logic [DW-1:0]        r_opa;
    logic [NPAIR*DW-1:0]  r_out;
    logic [DW-1:0]        w_sum;
    logic                 w_accept;
    logic                 w_last;

    // Single adder shared by all pairs; the odd element pairs with the latched even one
    mia_add_unit #(.DW(DW)) u_add (
        .i_a   (r_opa),
        .i_b   (in_data),
        .o_sum (w_sum)
    );

    assign w_last = (r_cnt == CW'(2*NPAIR-1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next state and handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b1;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start) w_state_nxt = LOAD;
            end
            LOAD: begin
                in_ready = 1'b1;
                w_accept = in_valid;
                if (in_valid && w_last) w_state_nxt = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Element counter, even-operand latch and result slots
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_opa <= '0;
            r_out <= '0;
        end else if (r_state == IDLE && start) begin
            r_cnt <= '0;
            r_out <= '0;
        end else if (w_accept) begin
            r_cnt <= r_cnt + 1'b1;
            if (!r_cnt[0])
                r_opa <= in_data;
            else
                r_out[slot_off(int'(r_cnt >> 1), NPAIR, DW) +: DW] <= w_sum;
        end
    end

    assign out = r_out;

endmodule

// File: tb/tb_matrix_add_seq_ctrl.sv
// Self-checking bench for matrix_add_seq_ctrl against a pair-sum reference model.
module tb_matrix_add_seq_ctrl;

    localparam int DW    = 16;
    localparam int NPAIR = 8;
    localparam int NEL   = 2*NPAIR;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [DW-1:0]       in_data = '0;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [NPAIR*DW-1:0] out;
    logic                busy;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0]       elems [NEL];
    logic [NPAIR*DW-1:0] exp_row;
    logic [NPAIR*DW-1:0] tmp_row;

    always #5 clk = ~clk;

    matrix_add_seq_ctrl #(.DW(DW), .NPAIR(NPAIR)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [NPAIR*DW-1:0] act, input logic [NPAIR*DW-1:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, act, expv);
        end
    endtask

    // Reference: true sum of each pair, then wrap or clamp, placed with pair 0 at the top
    function automatic logic [NPAIR*DW-1:0] model_row();
        logic [NPAIR*DW-1:0] r = '0;
        for (int k = 0; k < NPAIR; k++) begin
            int unsigned s = int'(elems[2*k]) + int'(elems[2*k+1]);
`ifdef MIA_ADD_SAT_EN
            if (s > 65535) s = 65535;
`else
            s = s % 65536;
`endif
            r[(NPAIR-1-k)*DW +: DW] = s[DW-1:0];
        end
        return r;
    endfunction

    // Start one operation, stream all elements with random gaps and stray starts,
    // hold the result for hold_cyc cycles, then hand it off.
    task automatic run_op(input string tag, input int vld_pct, input int hold_cyc);
        int idx = 0;
        int cyc = 0;
        logic v, rdy;
        exp_row = model_row();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy_load"}, {127'd0, busy}, 128'd1);
        chk({tag, "_out_cleared"}, out, '0);
        while (idx < NEL && cyc < 1000) begin
            v        = ($urandom_range(99) < vld_pct);
            in_valid = v;
            in_data  = v ? elems[idx] : DW'($urandom);
            start    = $urandom_range(1);
            rdy      = in_ready;
            if (!rdy || out_valid) begin
                chk({tag, "_load_ready"}, {126'd0, rdy, out_valid}, 128'd2);
            end
            @(posedge clk);
            if (v && rdy) idx++;
            @(negedge clk);
            cyc++;
        end
        if (idx < NEL) begin
            chk({tag, "_load_timeout"}, 128'(idx), 128'(NEL));
            return;
        end
        in_valid = $urandom_range(1);
        start    = 1'b0;
        // Last element was taken on the previous edge: result must be valid now
        chk({tag, "_valid_latency"}, {126'd0, out_valid, in_ready}, 128'd2);
        chk({tag, "_row"}, out, exp_row);
        for (int i = 0; i < hold_cyc; i++) begin
            out_ready = 1'b0;
            start     = 1'b1;
            in_valid  = 1'b1;
            in_data   = DW'($urandom);
            @(posedge clk);
            @(negedge clk);
            chk({tag, "_hold_flags"}, {125'd0, out_valid, in_ready, busy}, 128'd5);
            chk({tag, "_hold_row"}, out, exp_row);
        end
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_after_hs"}, {126'd0, out_valid, busy}, 128'd0);
        chk({tag, "_row_kept"}, out, exp_row);
    endtask

    initial begin
        // Reset state
        #12;
        chk("reset_flags", {125'd0, out_valid, in_ready, busy}, 128'd0);
        chk("reset_out", out, '0);
        @(negedge clk);
        rst = 1'b0;

        // in_valid in IDLE must not be consumed or wake the block
        in_valid = 1'b1;
        in_data  = 16'h1234;
        repeat (3) @(negedge clk);
        chk("idle_ignore", {125'd0, out_valid, in_ready, busy}, 128'd0);
        in_valid = 1'b0;

        // Test 1: elements 1..16 back to back, immediate handoff
        for (int i = 0; i < NEL; i++) elems[i] = DW'(i + 1);
        run_op("t1", 100, 0);
        tmp_row = out;
        chk("t1_top_slot", 128'(tmp_row[127:112]), 128'h0003);
        chk("t1_low_slot", 128'(tmp_row[15:0]), 128'h001F);

        // Test 2: overflowing pair in slot 2
        for (int i = 0; i < NEL; i++) elems[i] = DW'(i + 1);
        elems[4] = 16'hFFFF;
        elems[5] = 16'h0002;
        run_op("t2", 100, 1);
        tmp_row = out;
`ifdef MIA_ADD_SAT_EN
        chk("t2_slot", 128'(tmp_row[(NPAIR-1-2)*DW +: DW]), 128'hFFFF);
`else
        chk("t2_slot", 128'(tmp_row[(NPAIR-1-2)*DW +: DW]), 128'h0001);
`endif
        chk("t2_slot0", 128'(tmp_row[127:112]), 128'h0003);

        // Test 3: valid gaps and a 5-cycle stall in HOLD
        for (int i = 0; i < NEL; i++) elems[i] = DW'($urandom);
        run_op("t3", 50, 5);

        // Test 4: reset after 5 accepted elements
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = DW'(16'hA000 + i);
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("t4_rst_flags", {125'd0, out_valid, in_ready, busy}, 128'd0);
        chk("t4_rst_out", out, '0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NEL; i++) elems[i] = DW'(i + 1);
        run_op("t4", 100, 0);

        // Randomized operations including corner values
        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < NEL; i++) begin
                case ($urandom_range(3))
                    0: elems[i] = 16'hFFFF;
                    1: elems[i] = 16'h0000;
                    default: elems[i] = DW'($urandom);
                endcase
            end
            run_op("rnd", 30 + 10*n, $urandom_range(5));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
